// File: rtl/game_control_np.sv
// Turn-based board controller for PLAYERS players over CELLS squares: places one
// piece per key press, rejects illegal presses, counts moves and locks on win or draw.
module game_control_np #(
    parameter  int CELLS        = 9,
    parameter  int PLAYERS      = 2,
    parameter  int FIRST_PLAYER = 0,
    localparam int TW           = (PLAYERS > 2) ? $clog2(PLAYERS) : 1,
    localparam int MW           = $clog2(CELLS + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       game_finished,
    input  logic [CELLS-1:0]           square,
    output logic [PLAYERS*CELLS-1:0]   board_state,
    output logic [TW-1:0]              turn,
    output logic [MW-1:0]              move_count,
    output logic                       accepted,
    output logic                       illegal,
    output logic                       board_full,
    output logic                       locked
);

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        HELD   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [MW-1:0] LP_FULL  = MW'(CELLS);
    localparam logic [TW-1:0] LP_FIRST = TW'(FIRST_PLAYER);
    localparam logic [TW-1:0] LP_LAST  = TW'(PLAYERS - 1);

    state_t                     r_state;
    logic                       r_key_down;
    logic [PLAYERS*CELLS-1:0]   r_board;
    logic [TW-1:0]              r_turn;
    logic [MW-1:0]              r_move_count;
    logic                       r_accepted;
    logic                       r_illegal;
    logic                       r_board_full;
    logic                       r_locked;

    logic [CELLS-1:0]           w_part [PLAYERS];
    logic [CELLS-1:0]           w_occupied;
    logic                       w_onehot;
    logic                       w_legal;
    logic                       w_press;
    logic                       w_turn_bad;
    logic [TW-1:0]              w_turn_inc;

    // Running OR across the ownership planes gives the occupied map.
    for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_occ
        if (gi == 0) begin : g_first
            assign w_part[gi] = r_board[gi*CELLS +: CELLS];
        end else begin : g_rest
            assign w_part[gi] = w_part[gi-1] | r_board[gi*CELLS +: CELLS];
        end
    end

    assign w_occupied = w_part[PLAYERS-1];
    assign w_onehot   = (square != '0) && ((square & (square - CELLS'(1))) == '0);
    assign w_legal    = w_onehot && ((square & w_occupied) == '0);
    // A press only counts on the cycle the key goes down; a key held through reset waits for release.
    assign w_press    = (square != '0) && !r_key_down;
    assign w_turn_bad = ({1'b0, r_turn} >= (TW+1)'(PLAYERS));
    assign w_turn_inc = (r_turn == LP_LAST) ? '0 : r_turn + TW'(1);

    always_ff @(posedge clk) begin
        r_key_down <= (square != '0);
        if (reset) begin
            r_state      <= ARMED;
            r_board      <= '0;
            r_turn       <= LP_FIRST;
            r_move_count <= '0;
            r_accepted   <= 1'b0;
            r_illegal    <= 1'b0;
            r_board_full <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_accepted <= 1'b0;
            r_illegal  <= 1'b0;
            case (r_state)
                ARMED, HELD: begin
                    if (game_finished) begin
                        r_state  <= LOCKED;
                        r_locked <= 1'b1;
                    end else if (r_move_count == LP_FULL) begin
                        r_state      <= LOCKED;
                        r_locked     <= 1'b1;
                        r_board_full <= 1'b1;
                    end else if (r_state == ARMED) begin
                        if (w_press) begin
                            r_state <= HELD;
                            if (w_legal) begin
                                for (int p = 0; p < PLAYERS; p++) begin
                                    if (r_turn == TW'(p)) begin
                                        r_board[p*CELLS +: CELLS] <= r_board[p*CELLS +: CELLS] | square;
                                    end
                                end
                                r_turn       <= w_turn_inc;
                                r_move_count <= r_move_count + MW'(1);
                                r_accepted   <= 1'b1;
                            end else begin
                                r_illegal <= 1'b1;
                            end
                        end
                    end else if (square == '0) begin
                        r_state <= ARMED;
                    end
                end
                LOCKED: begin
                    r_state <= LOCKED;
                end
                default: begin
                    r_state <= ARMED;
                end
            endcase
            if (w_turn_bad) begin
                r_turn <= LP_FIRST;
            end
        end
    end

    assign board_state = r_board;
    assign turn        = r_turn;
    assign move_count  = r_move_count;
    assign accepted    = r_accepted;
    assign illegal     = r_illegal;
    assign board_full  = r_board_full;
    assign locked      = r_locked;

endmodule

// File: tb/tb_game_control_np.sv
// Directed bench for game_control_np: a default 2-player 3x3 instance and a
// 3-player 16-cell instance, checked with immediate assertions.
module tb_game_control_np;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance: CELLS=9, PLAYERS=2, FIRST_PLAYER=0
    logic        a_reset;
    logic        a_gf;
    logic [8:0]  a_square;
    logic [17:0] a_board;
    logic [0:0]  a_turn;
    logic [3:0]  a_count;
    logic        a_acc, a_ill, a_full, a_lock;

    // Three-player instance: CELLS=16, PLAYERS=3, FIRST_PLAYER=2
    logic        b_reset;
    logic        b_gf;
    logic [15:0] b_square;
    logic [47:0] b_board;
    logic [1:0]  b_turn;
    logic [4:0]  b_count;
    logic        b_acc, b_ill, b_full, b_lock;

    int n_checks = 0;
    int n_fail   = 0;

    game_control_np #(.CELLS(9), .PLAYERS(2), .FIRST_PLAYER(0)) dut_a (
        .clk(clk), .reset(a_reset), .game_finished(a_gf), .square(a_square),
        .board_state(a_board), .turn(a_turn), .move_count(a_count),
        .accepted(a_acc), .illegal(a_ill), .board_full(a_full), .locked(a_lock)
    );

    game_control_np #(.CELLS(16), .PLAYERS(3), .FIRST_PLAYER(2)) dut_b (
        .clk(clk), .reset(b_reset), .game_finished(b_gf), .square(b_square),
        .board_state(b_board), .turn(b_turn), .move_count(b_count),
        .accepted(b_acc), .illegal(b_ill), .board_full(b_full), .locked(b_lock)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        a_reset = 1'b1; a_gf = 1'b0; a_square = '0;
        b_reset = 1'b1; b_gf = 1'b0; b_square = '0;
        tick(); tick();
        a_reset = 1'b0;

        // Reset state
        chk("rst_board", 64'(a_board), 64'h0);
        chk("rst_turn",  64'(a_turn),  64'd0);
        chk("rst_count", 64'(a_count), 64'd0);
        chk("rst_acc",   64'(a_acc),   64'd0);
        chk("rst_ill",   64'(a_ill),   64'd0);
        chk("rst_full",  64'(a_full),  64'd0);
        chk("rst_lock",  64'(a_lock),  64'd0);

        // 1: one press held for three edges places exactly once
        a_square = 9'h001;
        tick();
        chk("t1_acc",   64'(a_acc),   64'd1);
        chk("t1_ill",   64'(a_ill),   64'd0);
        chk("t1_board", 64'(a_board), 64'h001);
        chk("t1_turn",  64'(a_turn),  64'd1);
        chk("t1_count", 64'(a_count), 64'd1);
        tick();
        chk("t1_acc_held1", 64'(a_acc), 64'd0);
        chk("t1_ill_held1", 64'(a_ill), 64'd0);
        tick();
        chk("t1_acc_held2", 64'(a_acc),   64'd0);
        chk("t1_cnt_held2", 64'(a_count), 64'd1);
        chk("t1_brd_held2", 64'(a_board), 64'h001);
        a_square = '0;
        tick();
        chk("t1_acc_rel", 64'(a_acc), 64'd0);

        // 2: occupied square, then a two-hot pattern
        a_square = 9'h001;
        tick();
        chk("t2_occ_ill",   64'(a_ill),   64'd1);
        chk("t2_occ_acc",   64'(a_acc),   64'd0);
        chk("t2_occ_turn",  64'(a_turn),  64'd1);
        chk("t2_occ_count", 64'(a_count), 64'd1);
        chk("t2_occ_board", 64'(a_board), 64'h001);
        tick();
        chk("t2_occ_ill_held", 64'(a_ill), 64'd0);
        a_square = '0;
        tick();
        a_square = 9'h006;
        tick();
        chk("t2_hot_ill",   64'(a_ill),   64'd1);
        chk("t2_hot_turn",  64'(a_turn),  64'd1);
        chk("t2_hot_count", 64'(a_count), 64'd1);
        chk("t2_hot_board", 64'(a_board), 64'h001);
        a_square = '0;
        tick();
        chk("t2_hot_ill_rel", 64'(a_ill), 64'd0);

        // 3: fresh game filled in cell order -> draw lock
        a_reset = 1'b1; tick(); a_reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk("t3_turn_before", 64'(a_turn), 64'(i % 2));
            a_square = 9'b1 << i;
            tick();
            chk("t3_acc",   64'(a_acc),   64'd1);
            chk("t3_count", 64'(a_count), 64'(i + 1));
            a_square = '0;
            tick();
        end
        chk("t3_count_fin", 64'(a_count), 64'd9);
        chk("t3_full",      64'(a_full),  64'd1);
        chk("t3_lock",      64'(a_lock),  64'd1);
        chk("t3_board",     64'(a_board), 64'h15555);
        chk("t3_occupied",  64'(a_board[17:9] | a_board[8:0]), 64'h1FF);
        chk("t3_turn_fin",  64'(a_turn),  64'd1);
        a_square = 9'h001;
        tick();
        chk("t3_locked_acc", 64'(a_acc), 64'd0);
        chk("t3_locked_ill", 64'(a_ill), 64'd0);
        a_square = '0;
        tick();

        // 4: win reported together with a legal press after five moves
        a_reset = 1'b1; tick(); a_reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_square = 9'b1 << i;
            tick();
            a_square = '0;
            tick();
        end
        chk("t4_pre_count", 64'(a_count), 64'd5);
        chk("t4_pre_lock",  64'(a_lock),  64'd0);
        a_square = 9'h020;
        a_gf = 1'b1;
        tick();
        chk("t4_acc",   64'(a_acc),   64'd0);
        chk("t4_ill",   64'(a_ill),   64'd0);
        chk("t4_lock",  64'(a_lock),  64'd1);
        chk("t4_full",  64'(a_full),  64'd0);
        chk("t4_count", 64'(a_count), 64'd5);
        chk("t4_board", 64'(a_board), 64'h1415);
        a_square = '0;
        a_gf = 1'b0;
        tick();
        chk("t4_lock_hold", 64'(a_lock), 64'd1);

        // 5: reset while a key is held mid-game
        a_reset = 1'b1; tick(); a_reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_square = 9'b1 << i;
            tick();
            a_square = '0;
            tick();
        end
        a_square = 9'h004;
        tick();
        chk("t5_pre_turn",  64'(a_turn),  64'd1);
        chk("t5_pre_count", 64'(a_count), 64'd3);
        tick();
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        chk("t5_rst_board", 64'(a_board), 64'h0);
        chk("t5_rst_turn",  64'(a_turn),  64'd0);
        chk("t5_rst_count", 64'(a_count), 64'd0);
        chk("t5_rst_acc",   64'(a_acc),   64'd0);
        tick();
        chk("t5_held_acc",   64'(a_acc),   64'd0);
        chk("t5_held_board", 64'(a_board), 64'h0);
        a_square = '0;
        tick();
        a_square = 9'h002;
        tick();
        chk("t5_new_acc",   64'(a_acc),   64'd1);
        chk("t5_new_board", 64'(a_board), 64'h002);
        chk("t5_new_turn",  64'(a_turn),  64'd1);
        a_square = '0;
        tick();

        // 6: three players, first player 2
        b_reset = 1'b0;
        chk("t6_rst_turn", 64'(b_turn), 64'd2);
        for (int i = 0; i < 4; i++) begin
            chk("t6_turn_before", 64'(b_turn), 64'((i + 2) % 3));
            b_square = 16'b1 << i;
            tick();
            chk("t6_acc", 64'(b_acc), 64'd1);
            chk("t6_piece_plane", 64'(b_board[((i + 2) % 3) * 16 + i]), 64'd1);
            b_square = '0;
            tick();
        end
        chk("t6_board", 64'(b_board), 64'h9_0004_0002);
        chk("t6_count", 64'(b_count), 64'd4);
        chk("t6_turn",  64'(b_turn),  64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
